// File: rtl/q_reg_sched.sv
// q_reg_sched: sequencer for the quotient-digit register/RAM writer.
// Packs digits MSB-first into UNROLLING-bit words, left-aligns the tail word.
//
// Ports:
//   clk, asyn_reset (async, active-low)
//   start, num_digits  - launch a division of num_digits digits (IDLE only)
//   stall              - freeze sequencing this cycle
//   enable, refresh    - write/shift enable, first digit of a new word
//   accum, counter     - word address, digit index
//   shift_cnt          - left-alignment shift during the flush cycle
//   busy, done         - in progress, one-cycle completion pulse
module q_reg_sched #(
    parameter int UNROLLING    = 64,
    parameter int ONLINE_DELAY = 3,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic [10:0]           num_digits,
    input  logic                  stall,
    output logic                  enable,
    output logic                  refresh,
    output logic [ADDR_WIDTH-1:0] accum,
    output logic [10:0]           counter,
    output logic [10:0]           shift_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int LOG2U = $clog2(UNROLLING);
    localparam int DW    = (ONLINE_DELAY > 1) ? $clog2(ONLINE_DELAY) : 1;
    localparam logic [10:0]   UMASK = 11'(UNROLLING - 1);
    localparam logic [DW-1:0] DLAST =
        DW'((ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           dcnt_q, dcnt_d;
    logic [10:0]             n_q, n_d;
    logic                    enable_q, enable_d;
    logic                    refresh_q, refresh_d;
    logic [ADDR_WIDTH-1:0]   accum_q, accum_d;
    logic [10:0]             counter_q, counter_d;
    logic [10:0]             shift_q, shift_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [10:0]             next_k;

    // Outputs are computed one edge ahead: state_q is the phase whose
    // outputs are currently visible, and the block below builds the next.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        n_d       = n_q;
        enable_d  = 1'b0;
        refresh_d = 1'b0;
        accum_d   = accum_q;
        counter_d = counter_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        next_k    = counter_q + 11'd1;

        unique case (state_q)
            S_IDLE: begin
                accum_d   = '0;
                counter_d = '0;
                shift_d   = '0;
                busy_d    = 1'b0;
                if (start) begin
                    if (num_digits == 11'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        n_d    = num_digits;
                        dcnt_d = '0;
                        busy_d = 1'b1;
                        if (ONLINE_DELAY == 0) begin
                            state_d   = S_RUN;
                            enable_d  = 1'b1;
                            refresh_d = 1'b1;
                        end else begin
                            state_d = S_DELAY;
                        end
                    end
                end
            end
            S_DELAY: begin
                if (!stall) begin
                    if (dcnt_q == DLAST) begin
                        state_d   = S_RUN;
                        enable_d  = 1'b1;
                        refresh_d = 1'b1;
                        accum_d   = '0;
                        counter_d = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                // A stalled cycle re-shows the last digit with enable low;
                // that digit was already written, so resume at counter+1.
                if (!stall) begin
                    enable_d = 1'b1;
                    if (counter_q == n_q - 11'd1) begin
                        state_d   = S_FLUSH;
                        counter_d = n_q;
                        // (U - N mod U) mod U == (-N) mod U
                        shift_d   = (11'd0 - n_q) & UMASK;
                    end else begin
                        counter_d = next_k;
                        refresh_d = ((next_k & UMASK) == 11'd0);
                        accum_d   = ADDR_WIDTH'(next_k >> LOG2U);
                    end
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    accum_d   = '0;
                    counter_d = '0;
                    shift_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_q   <= S_IDLE;
            dcnt_q    <= '0;
            n_q       <= '0;
            enable_q  <= 1'b0;
            refresh_q <= 1'b0;
            accum_q   <= '0;
            counter_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            n_q       <= n_d;
            enable_q  <= enable_d;
            refresh_q <= refresh_d;
            accum_q   <= accum_d;
            counter_q <= counter_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign enable    = enable_q;
    assign refresh   = refresh_q;
    assign accum     = accum_q;
    assign counter   = counter_q;
    assign shift_cnt = shift_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_q_reg_sched.sv
// tb_q_reg_sched: randomized self-checking bench for q_reg_sched.
// Reference model: a flat per-division schedule of expected output cycles.
module tb_q_reg_sched;

    localparam int U = 64;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        asyn_reset;
    logic        start;
    logic [10:0] num_digits;
    logic        stall;

    logic        enable, refresh, busy, done;
    logic [6:0]  accum;
    logic [10:0] counter, shift_cnt;

    logic        b_en, b_rf, b_bsy, b_dn;
    logic [0:0]  b_acc;
    logic [10:0] b_cnt, b_sh;

    always #5 clk = ~clk;

    q_reg_sched #(.UNROLLING(64), .ONLINE_DELAY(3), .ADDR_WIDTH(7)) dut (
        .clk(clk), .asyn_reset(asyn_reset), .start(start),
        .num_digits(num_digits), .stall(stall),
        .enable(enable), .refresh(refresh), .accum(accum),
        .counter(counter), .shift_cnt(shift_cnt),
        .busy(busy), .done(done)
    );

    q_reg_sched #(.UNROLLING(64), .ONLINE_DELAY(3), .ADDR_WIDTH(1)) dut_a1 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start),
        .num_digits(num_digits), .stall(stall),
        .enable(b_en), .refresh(b_rf), .accum(b_acc),
        .counter(b_cnt), .shift_cnt(b_sh),
        .busy(b_bsy), .done(b_dn)
    );

    typedef struct packed {
        logic        en;
        logic        rf;
        logic [10:0] word;
        logic [10:0] cnt;
        logic [10:0] sh;
        logic        bsy;
        logic        dn;
    } exp_t;

    exp_t sched[$];
    exp_t m_cur;
    int   m_idx;
    bit   m_active;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    wire [59:0] act = {enable, refresh, accum, counter, shift_cnt, busy, done,
                       b_en, b_rf, b_acc, b_cnt, b_sh, b_bsy, b_dn};

    function automatic exp_t mk(input bit en, input bit rf, input int word,
                                input int cnt, input int sh,
                                input bit bsy, input bit dn);
        exp_t e;
        e.en   = en;
        e.rf   = rf;
        e.word = 11'(word);
        e.cnt  = 11'(cnt);
        e.sh   = 11'(sh);
        e.bsy  = bsy;
        e.dn   = dn;
        return e;
    endfunction

    function automatic logic [59:0] expv();
        logic [10:0] w;
        w = m_cur.word;
        return {m_cur.en, m_cur.rf, w[6:0], m_cur.cnt, m_cur.sh,
                m_cur.bsy, m_cur.dn,
                m_cur.en, m_cur.rf, w[0], m_cur.cnt, m_cur.sh,
                m_cur.bsy, m_cur.dn};
    endfunction

    task automatic model_start(input int n);
        sched.delete();
        if (n > 0) begin
            for (int i = 0; i < D; i++)
                sched.push_back(mk(0, 0, 0, 0, 0, 1, 0));
            for (int k = 0; k < n; k++)
                sched.push_back(mk(1, (k % U) == 0, k / U, k, 0, 1, 0));
            sched.push_back(mk(1, 0, (n - 1) / U, n, (U - n % U) % U, 1, 0));
        end
        sched.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        m_idx    = 0;
        m_active = 1;
        m_cur    = sched[0];
    endtask

    task automatic model_reset();
        m_active = 0;
        m_cur    = '0;
    endtask

    task automatic model_edge(input bit s, input int nd, input bit st);
        if (!asyn_reset) begin
            model_reset();
        end else if (!m_active) begin
            if (s) model_start(nd);
            else   m_cur = '0;
        end else if (m_cur.bsy && st) begin
            m_cur.en = 0;
            m_cur.rf = 0;
        end else begin
            m_idx++;
            if (m_idx >= sched.size()) begin
                m_active = 0;
                m_cur    = '0;
            end else begin
                m_cur = sched[m_idx];
            end
        end
    endtask

    task automatic cycle(input bit s, input logic [10:0] nd, input bit st);
        start      = s;
        num_digits = nd;
        stall      = st;
        @(posedge clk);
        model_edge(s, int'(nd), st);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        asyn_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 11'd0, 0);
            n_cmp++;
            if (act !== expv()) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, act, expv());
            end
        end
        asyn_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 11'd0, 0);
            n_cmp++;
            if (act !== expv()) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, act, expv());
            end
        end
        cycle(1, 11'd40, 0);
        cycle(0, 11'd0, 1);
        cycle(0, 11'd0, 1);
        n_cmp++;
        if (act !== expv()) begin
            n_bad++;
            $display("FAIL delay_hold cyc=%0d got=%h want=%h", cyc, act, expv());
        end
        asyn_reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (act !== 60'd0) begin
            n_bad++;
            $display("FAIL reset_async cyc=%0d got=%h want=0", cyc, act);
        end
        cycle(0, 11'd0, 0);
        asyn_reset = 1'b1;
        cycle(0, 11'd0, 0);
        n_cmp++;
        if (act !== expv()) begin
            n_bad++;
            $display("FAIL reset_after cyc=%0d got=%h want=%h", cyc, act, expv());
        end
    endtask

    task automatic test_basic();
        int t_done = -1;
        int n_en = 0;
        cycle(1, 11'd5, 0);
        for (int t = 1; t <= 14; t++) begin
            if (t > 1) cycle(0, 11'($urandom), 0);
            n_cmp++;
            if (act !== expv()) begin
                n_bad++;
                $display("FAIL basic t=%0d got=%h want=%h", t, act, expv());
            end
            if (done) t_done = t;
            if (enable) n_en++;
        end
        n_cmp++;
        if (t_done !== 10) begin
            n_bad++;
            $display("FAIL basic_done_cycle got=%0d want=10", t_done);
        end
        n_cmp++;
        if (n_en !== 6) begin
            n_bad++;
            $display("FAIL basic_enable_count got=%0d want=6", n_en);
        end
    endtask

    task automatic test_wrap();
        int lens[2] = '{130, 128};
        foreach (lens[j]) begin
            int t = 1;
            int t_done = -1;
            cycle(1, 11'(lens[j]), 0);
            n_cmp++;
            if (act !== expv()) begin
                n_bad++;
                $display("FAIL wrap n=%0d t=%0d got=%h want=%h", lens[j], t, act, expv());
            end
            while (m_active && t < 400) begin
                cycle(0, 11'd0, 0);
                t++;
                n_cmp++;
                if (act !== expv()) begin
                    n_bad++;
                    $display("FAIL wrap n=%0d t=%0d got=%h want=%h", lens[j], t, act, expv());
                end
                if (done) t_done = t;
            end
            n_cmp++;
            if (t_done !== lens[j] + D + 2) begin
                n_bad++;
                $display("FAIL wrap_done_cycle n=%0d got=%0d want=%0d", lens[j], t_done, lens[j] + D + 2);
            end
        end
    endtask

    task automatic test_stall();
        int t = 1;
        int t_done = -1;
        int n_six = 0;
        int stall_left = 0;
        bit stalled = 0;
        bit s;
        cycle(1, 11'd10, 0);
        while (m_active && t < 100) begin
            s = (enable && counter == 11'd2);
            if (enable && counter == 11'd6 && !stalled) begin
                stalled    = 1;
                stall_left = 3;
            end
            cycle(s, 11'd7, stall_left > 0);
            if (stall_left > 0) stall_left--;
            t++;
            n_cmp++;
            if (act !== expv()) begin
                n_bad++;
                $display("FAIL stall t=%0d got=%h want=%h", t, act, expv());
            end
            if (done) t_done = t;
            if (counter == 11'd6) n_six++;
        end
        n_cmp++;
        if (t_done !== 18) begin
            n_bad++;
            $display("FAIL stall_done_cycle got=%0d want=18", t_done);
        end
        n_cmp++;
        if (n_six !== 4) begin
            n_bad++;
            $display("FAIL stall_counter6_cycles got=%0d want=4", n_six);
        end
    endtask

    task automatic test_abort();
        int guard = 0;
        cycle(1, 11'd100, 0);
        while (!(enable && counter == 11'd20) && guard < 200) begin
            cycle(0, 11'd0, 0);
            guard++;
        end
        n_cmp++;
        if (act !== expv()) begin
            n_bad++;
            $display("FAIL abort_pre got=%h want=%h", act, expv());
        end
        asyn_reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (act !== 60'd0) begin
            n_bad++;
            $display("FAIL abort_async got=%h want=0", act);
        end
        #3;
        asyn_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 11'd0, 0);
            n_cmp++;
            if (act !== expv()) begin
                n_bad++;
                $display("FAIL abort_idle i=%0d got=%h want=%h", i, act, expv());
            end
        end
        cycle(1, 11'd0, 0);
        n_cmp++;
        if (act !== expv() || done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_digits got=%h want=%h", act, expv());
        end
        cycle(0, 11'd0, 0);
        n_cmp++;
        if (act !== expv()) begin
            n_bad++;
            $display("FAIL zero_digits_after got=%h want=%h", act, expv());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int nd;
            int guard = 0;
            case (r % 4)
                0:       nd = (r == 4) ? 0 : $urandom_range(1, 3);
                1:       nd = 64 * $urandom_range(1, 4);
                default: nd = $urandom_range(1, 300);
            endcase
            cycle(1, 11'(nd), $urandom_range(0, 1) == 0);
            n_cmp++;
            if (act !== expv()) begin
                n_bad++;
                $display("FAIL random r=%0d n=%0d got=%h want=%h", r, nd, act, expv());
            end
            while (m_active && guard < 1500) begin
                cycle($urandom_range(0, 7) == 0, 11'($urandom),
                      $urandom_range(0, 3) == 0);
                guard++;
                n_cmp++;
                if (act !== expv()) begin
                    n_bad++;
                    $display("FAIL random r=%0d n=%0d cyc=%0d got=%h want=%h", r, nd, cyc, act, expv());
                end
            end
            if (m_active) begin
                n_bad++;
                $display("FAIL random_timeout r=%0d n=%0d", r, nd);
                model_reset();
                asyn_reset = 1'b0;
                #1;
                asyn_reset = 1'b1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        asyn_reset = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        num_digits = '0;
        m_cur      = '0;
        m_active   = 0;
        m_idx      = 0;
        test_reset();
        test_basic();
        cycle(0, 11'd0, 0);
        test_wrap();
        cycle(0, 11'd0, 0);
        test_stall();
        cycle(0, 11'd0, 0);
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
